bram_req_adapter: RTL and testbench

- Request-side front end for one port of the byte-enabled dual-port BRAM.
- Accepts load/store requests from the core's memory stage over a valid/ready handshake and drives the BRAM port's EN/WE/ADDR/DI.
- Tracks the BRAM's fixed read latency and returns load data through a credit-guarded response FIFO, so responses are never dropped under backpressure.

---
 rtl/bram_req_adapter.sv | 145 ++++++++++++++
 tb/tb_bram_req_adapter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_req_adapter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------------------------
// bram_req_adapter
//
// Request-side front end for one port of the byte-enabled dual-port BRAM. Load/store requests
// from the memory stage arrive over a valid/ready handshake and are driven straight onto the
// BRAM port. Loads are tagged through an L-deep shift register (L = 1 + PIPELINED) so BRAM DO
// is captured only in the cycle it is valid. The captured data goes into a small response FIFO.
// A credit counter (queued responses + loads in flight) stops new requests from being accepted
// while every FIFO slot is already spoken for, so a response is never dropped.
//
// Optional build macro:
//   BRAM_REQ_ADAPTER_BYPASS_EN - when the FIFO is empty, load data is presented on the response
//                                port in the cycle it leaves the BRAM (latency L, not L+1).
//
// Ports:
//   CLK, RST          clock shared with the BRAM port; synchronous active-high reset
//   req_valid/ready   request handshake
//   req_addr          word address
//   req_wstrb         byte enables; all-zero means load, anything else means store
//   req_wdata         store data
//   resp_valid/ready  load response handshake
//   resp_rdata        load data, held while stalled
//   bram_en/we/addr/di  BRAM port controls and write data
//   bram_do           BRAM read data
//   busy              loads in flight or responses still queued
// ---------------------------------------------------------------------------------------------
module bram_req_adapter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WE_WIDTH   = 4,
    parameter int unsigned PIPELINED  = 0,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WE_WIDTH-1:0]   req_wstrb,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  bram_en,
    output logic [WE_WIDTH-1:0]   bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do,
    output logic                  busy
);

    localparam int unsigned Lat  = 1 + PIPELINED;
    localparam int unsigned PtrW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(RESP_DEPTH);

    logic                  fire;
    logic                  load_fire;
    logic                  tag_end;
    logic                  bypass;
    logic                  push;
    logic                  pop;
    logic                  resp_fire;
    logic                  fifo_empty;
    logic [Lat-1:0]        tag_q;
    logic [Lat-1:0]        tag_d;
    logic [CntW-1:0]       cnt_q;
    logic [CntW-1:0]       cnt_d;
    logic [CntW-1:0]       fifo_cnt_q;
    logic [CntW-1:0]       fifo_cnt_d;
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];

    // Request side. Stores also wait for a credit so req_ready never depends on req_wstrb.
    always_comb begin
        req_ready = !RST && (cnt_q < DepthCnt);
        fire      = req_valid && req_ready;
        load_fire = fire && (req_wstrb == '0);
        bram_en   = fire;
        bram_we   = fire ? req_wstrb : '0;
        bram_addr = req_addr;
        bram_di   = req_wdata;
    end

    // Load tag pipeline: the last stage is high exactly when BRAM DO holds that load's data.
    if (Lat == 1) begin : g_tag_lat1
        assign tag_d = load_fire;
    end else begin : g_tag_latn
        assign tag_d = {tag_q[Lat-2:0], load_fire};
    end

    assign tag_end    = tag_q[Lat-1];
    assign fifo_empty = (fifo_cnt_q == '0);

`ifdef BRAM_REQ_ADAPTER_BYPASS_EN
    // Empty FIFO: forward BRAM DO directly; it is enqueued only if the consumer stalls.
    assign bypass     = fifo_empty && tag_end;
    assign resp_rdata = fifo_empty ? bram_do : mem_q[rd_ptr_q];
`else
    assign bypass     = 1'b0;
    assign resp_rdata = mem_q[rd_ptr_q];
`endif

    always_comb begin
        resp_valid = !RST && (!fifo_empty || bypass);
        resp_fire  = resp_valid && resp_ready;
        push       = tag_end && !(bypass && resp_ready);
        // A bypassed response leaves without touching the FIFO.
        pop        = resp_fire && !fifo_empty;
        // A credit is taken at load acceptance and returned when the response is consumed.
        cnt_d      = cnt_q + CntW'(load_fire) - CntW'(resp_fire);
        fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
        busy       = (cnt_q != '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_q      <= '0;
            cnt_q      <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Storage needs no reset; validity is tracked by fifo_cnt_q.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem_q[wr_ptr_q] <= bram_do;
        end
    end

endmodule

// File: tb/tb_bram_req_adapter.sv
`timescale 1ns/1ps
module tb_bram_req_adapter;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned WW    = 4;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [DW-1:0] data;
        int            t_acc;
        bit            chk_lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Configuration 0: PIPELINED=0, configuration 1: PIPELINED=1.
    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int unsigned PIPE = g;
        localparam int unsigned LAT  = 1 + PIPE;
`ifdef BRAM_REQ_ADAPTER_BYPASS_EN
        localparam int EXP_LAT = LAT;
`else
        localparam int EXP_LAT = LAT + 1;
`endif

        logic          rst;
        logic          req_valid;
        logic          req_ready;
        logic [AW-1:0] req_addr;
        logic [WW-1:0] req_wstrb;
        logic [DW-1:0] req_wdata;
        logic          resp_valid;
        logic          resp_ready;
        logic [DW-1:0] resp_rdata;
        logic          bram_en;
        logic [WW-1:0] bram_we;
        logic [AW-1:0] bram_addr;
        logic [DW-1:0] bram_di;
        logic [DW-1:0] bram_do;
        logic          busy;

        bit   done      = 1'b0;
        bit   lat_chk   = 1'b0;
        int   cyc       = 0;
        int   en_pulses = 0;
        exp_t exp_q[$];

        bram_req_adapter #(
            .ADDR_WIDTH(AW),
            .DATA_WIDTH(DW),
            .WE_WIDTH  (WW),
            .PIPELINED (PIPE),
            .RESP_DEPTH(DEPTH)
        ) u_dut (
            .CLK       (clk),
            .RST       (rst),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_addr  (req_addr),
            .req_wstrb (req_wstrb),
            .req_wdata (req_wdata),
            .resp_valid(resp_valid),
            .resp_ready(resp_ready),
            .resp_rdata(resp_rdata),
            .bram_en   (bram_en),
            .bram_we   (bram_we),
            .bram_addr (bram_addr),
            .bram_di   (bram_di),
            .bram_do   (bram_do),
            .busy      (busy)
        );

        // Write-first byte-enabled BRAM; DO holds its last value on idle cycles.
        logic [DW-1:0] ram [0:255];
        logic [DW-1:0] stage1;
        logic [DW-1:0] stage2;
        logic [DW-1:0] w;

        always @(posedge clk) begin
            cyc <= cyc + 1;
            if (bram_en) begin
                w = ram[bram_addr[7:0]];
                for (int b = 0; b < WW; b++) begin
                    if (bram_we[b]) w[8*b +: 8] = bram_di[8*b +: 8];
                end
                if (bram_we != '0) ram[bram_addr[7:0]] <= w;
                stage1 <= w;
            end
            stage2 <= stage1;
        end
        assign bram_do = (PIPE == 0) ? stage1 : stage2;

        always @(negedge clk) begin
            if (bram_en) en_pulses++;
        end

        task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL cfg%0d %s: got 0x%0h, want 0x%0h", PIPE, name, got, want);
            end
        endtask

        // Response monitor / scoreboard.
        always @(negedge clk) begin
            exp_t e;
            if (!rst && resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL cfg%0d unexpected_resp: got 0x%0h, want no response",
                             PIPE, resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.data);
                    if (e.chk_lat) chk("resp_latency", cyc + 1 - e.t_acc, EXP_LAT);
                end
            end
        end

        task automatic sync();
            @(posedge clk);
            #1;
        endtask

        // Offer one request (called just after a rising edge); returns cycles waited.
        task automatic issue(input logic [AW-1:0] a, input logic [WW-1:0] ws,
                             input logic [DW-1:0] wd, input logic [DW-1:0] exp_data,
                             output int waits);
            exp_t e;
            req_valid = 1'b1;
            req_addr  = a;
            req_wstrb = ws;
            req_wdata = wd;
            waits     = 0;
            @(negedge clk);
            while (!req_ready && waits < 100) begin
                waits++;
                @(negedge clk);
            end
            if (!req_ready) begin
                chk("accept_timeout", 32'(waits), 32'd0);
            end else if (ws == '0) begin
                e.data    = exp_data;
                e.t_acc   = cyc + 1;
                e.chk_lat = lat_chk;
                exp_q.push_back(e);
                if (exp_q.size() > DEPTH) chk("fifo_overflow", exp_q.size(), DEPTH);
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            req_wstrb = '0;
        endtask

        task automatic drain();
            int n = 0;
            while (exp_q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("drain_empty", exp_q.size(), 0);
        endtask

        initial begin
            int wt;
            int p0;
            rst        = 1'b1;
            req_valid  = 1'b1;
            req_addr   = 16'h0010;
            req_wstrb  = 4'hF;
            req_wdata  = '0;
            resp_ready = 1'b1;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_bram_en", bram_en, 0);
            chk("rst_bram_we", bram_we, 0);
            chk("rst_resp_valid", resp_valid, 0);
            @(posedge clk);
            #1;
            rst       = 1'b0;
            req_valid = 1'b0;
            req_wstrb = '0;
            @(negedge clk);
            chk("post_rst_req_ready", req_ready, 1);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_resp_valid", resp_valid, 0);
            sync();

            // Preload through store requests; stores return nothing and take no credit.
            issue(16'h0010, 4'hF, 32'hDEADBEEF, '0, wt);
            issue(16'h0020, 4'hF, 32'h11223344, '0, wt);
            for (int i = 0; i < 8; i++) issue(AW'(i), 4'hF, 32'hC0DE0000 + i, '0, wt);
            chk("store_busy", busy, 0);
            repeat (4) @(negedge clk);
            chk("store_no_resp", resp_valid, 0);
            sync();

            // Single load.
            lat_chk = 1'b1;
            p0 = en_pulses;
            issue(16'h0010, 4'h0, '0, 32'hDEADBEEF, wt);
            drain();
            chk("single_en_pulses", en_pulses - p0, 1);
            sync();
            chk("single_busy_after", busy, 0);

            // Partial store followed immediately by a load of the same word.
            issue(16'h0020, 4'b0101, 32'hAABBCCDD, '0, wt);
            issue(16'h0020, 4'h0, '0, 32'h11BB33DD, wt);
            drain();
            sync();

            // Back-to-back loads 0..7.
            for (int i = 0; i < 8; i++) begin
                issue(AW'(i), 4'h0, '0, 32'hC0DE0000 + i, wt);
                chk("b2b_accept_wait", wt, 0);
            end
            drain();
            sync();

            // Backpressure: four credits, then stall.
            lat_chk    = 1'b0;
            resp_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
                issue(AW'(i), 4'h0, '0, 32'hC0DE0000 + i, wt);
                chk("bp_accept_wait", wt, 0);
            end
            req_valid = 1'b1;
            req_addr  = 16'h0004;
            req_wstrb = 4'h0;
            repeat (3) begin
                @(negedge clk);
                chk("bp_req_ready", req_ready, 0);
                chk("bp_busy", busy, 1);
                chk("bp_resp_valid", resp_valid, 1);
                chk("bp_hold_rdata", resp_rdata, 32'hC0DE0000);
            end
            sync();
            resp_ready = 1'b1;
            issue(16'h0004, 4'h0, '0, 32'hC0DE0004, wt);
            issue(16'h0005, 4'h0, '0, 32'hC0DE0005, wt);
            drain();
            sync();

            // Accept and pop in the same cycle at three credits used.
            resp_ready = 1'b0;
            for (int i = 5; i < 8; i++) issue(AW'(i), 4'h0, '0, 32'hC0DE0000 + i, wt);
            repeat (3) sync();
            resp_ready = 1'b1;
            issue(16'h0001, 4'h0, '0, 32'hC0DE0001, wt);
            chk("accpop_accept_wait", wt, 0);
            resp_ready = 1'b0;
            issue(16'h0002, 4'h0, '0, 32'hC0DE0002, wt);
            chk("accpop_ready_held", wt, 0);
            req_valid = 1'b1;
            req_addr  = 16'h0003;
            req_wstrb = 4'h0;
            @(negedge clk);
            chk("accpop_full", req_ready, 0);
            sync();
            resp_ready = 1'b1;
            issue(16'h0003, 4'h0, '0, 32'hC0DE0003, wt);
            drain();
            sync();

            // Reset with loads in flight and a response queued.
            resp_ready = 1'b0;
            for (int i = 0; i < 3; i++) issue(AW'(i), 4'h0, '0, 32'hC0DE0000 + i, wt);
            rst       = 1'b1;
            req_valid = 1'b1;
            req_addr  = 16'h0004;
            req_wstrb = 4'h0;
            exp_q.delete();
            @(negedge clk);
            chk("midrst_req_ready", req_ready, 0);
            chk("midrst_bram_en", bram_en, 0);
            chk("midrst_resp_valid", resp_valid, 0);
            @(posedge clk);
            #1;
            rst       = 1'b0;
            req_valid = 1'b0;
            @(negedge clk);
            chk("after_rst_resp_valid", resp_valid, 0);
            chk("after_rst_busy", busy, 0);
            chk("after_rst_req_ready", req_ready, 1);
            resp_ready = 1'b1;
            repeat (5) begin
                @(negedge clk);
                chk("after_rst_no_resp", resp_valid, 0);
            end
            sync();
            lat_chk = 1'b1;
            issue(16'h0010, 4'h0, '0, 32'hDEADBEEF, wt);
            drain();
            sync();
            done = 1'b1;
        end
    end

    initial begin
        bit fin = 1'b0;
        for (int t = 0; t < 20000 && !fin; t++) begin
            @(posedge clk);
            fin = g_cfg[0].done && g_cfg[1].done;
        end
        if (!fin) begin
            miscompares++;
            $display("FAIL global_timeout: got incomplete run, want both configurations done");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
